rca_seq_ctrl: RTL and testbench

Nibble-serial sequencer that computes a WIDTH-bit sum using a single external 4-bit ripple-carry adder slice (add4), instantiated beside it. It latches two operands on a start handshake and presents one nibble pair per clock to the slice. It chains the slice carry through a register and assembles the result, so a wide add costs one 4-bit adder plus WIDTH/4 cycles.

---
 rtl/rca_seq_ctrl.sv | 102 ++++++++++
 tb/tb_rca_seq_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rca_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rca_seq_ctrl
// Purpose  : Nibble-serial WIDTH-bit adder controller driving one external
//            4-bit ripple-carry slice, one nibble per clock.
// Revision : 1.0 - initial release
// ============================================================================
module rca_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_s,
  input  logic             add_cout
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0]    S_IDLE = 1'b0;
  localparam logic [0:0]    S_RUN  = 1'b1;
  localparam logic [IW-1:0] C_LAST = IW'(N - 1);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("rca_seq_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  logic [IW+1:0]    w_base;

  // Bit offset of the active nibble.
  assign w_base = {r_idx, 2'b00};
  assign busy   = (r_state == S_RUN);

  always_comb begin
    add_a   = 4'd0;
    add_b   = 4'd0;
    add_cin = 1'b0;
    if (r_state == S_RUN) begin
      add_a   = r_a[w_base +: 4];
      add_b   = r_b[w_base +: 4];
      add_cin = r_carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      s       <= '0;
      c_out   <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= c_in;
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          s[w_base +: 4] <= add_s;
          r_carry        <= add_cout;
          if (r_idx == C_LAST) begin
            c_out   <= add_cout;
            done    <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rca_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rca_seq_ctrl
// Purpose  : Directed, table-driven bench for rca_seq_ctrl at WIDTH=16 and 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rca_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        start16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, cout16;
  logic [15:0] s16;
  logic [3:0]  aa16, ab16, as16;
  logic        acin16, acout16;
  assign {acout16, as16} = {1'b0, aa16} + {1'b0, ab16} + {4'd0, acin16};

  // 4-bit instance
  logic        start4 = 1'b0, cin4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4, cout4;
  logic [3:0]  s4;
  logic [3:0]  aa4, ab4, as4;
  logic        acin4, acout4;
  assign {acout4, as4} = {1'b0, aa4} + {1'b0, ab4} + {4'd0, acin4};

  rca_seq_ctrl #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .c_in(cin16),
    .busy(busy16), .done(done16), .s(s16), .c_out(cout16),
    .add_a(aa16), .add_b(ab16), .add_cin(acin16), .add_s(as16), .add_cout(acout16)
  );

  rca_seq_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .c_in(cin4),
    .busy(busy4), .done(done4), .s(s4), .c_out(cout4),
    .add_a(aa4), .add_b(ab4), .add_cin(acin4), .add_s(as4), .add_cout(acout4)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          w;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
  } vec_t;

  vec_t vt[9];

  // Issue one start pulse and wait (bounded) for done; checks latency, busy span, result.
  task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [15:0] exp_s, input logic exp_co,
                        input string tag);
    int lat;
    int busy_cnt;
    logic [15:0] got_s;
    logic got_co;
    lat = 0;
    busy_cnt = 0;
    @(negedge clk);
    if (w == 4) begin
      a4 = a[3:0]; b4 = b[3:0]; cin4 = cin; start4 = 1'b1;
    end else begin
      a16 = a; b16 = b; cin16 = cin; start16 = 1'b1;
    end
    @(posedge clk); #1;
    start4 = 1'b0; start16 = 1'b0;
    if ((w == 4) ? busy4 : busy16) busy_cnt++;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if ((w == 4) ? done4 : done16) begin
        lat = k;
        break;
      end
      if ((w == 4) ? busy4 : busy16) busy_cnt++;
    end
    got_s  = (w == 4) ? {12'd0, s4} : s16;
    got_co = (w == 4) ? cout4 : cout16;
    check({tag, " latency"}, lat, w / 4);
    check({tag, " busy cycles"}, busy_cnt, w / 4);
    check({tag, " s"}, {16'd0, got_s}, {16'd0, exp_s});
    check({tag, " c_out"}, {31'd0, got_co}, {31'd0, exp_co});
  endtask

  logic [15:0] ops_a[3];
  logic [15:0] ops_b[3];
  logic        ops_c[3];

  initial begin
    int ndone;
    int acc;
    int last_k;
    logic busy_prev;
    logic [15:0] cap_s;

    vt[0] = '{16, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vt[1] = '{16, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vt[2] = '{16, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vt[3] = '{16, 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1};
    vt[4] = '{16, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    vt[5] = '{4,  16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0};
    vt[6] = '{4,  16'h000C, 16'h000F, 1'b0, 16'h000B, 1'b1};
    vt[7] = '{4,  16'h000D, 16'h000D, 1'b0, 16'h000A, 1'b1};
    vt[8] = '{4,  16'h0006, 16'h0009, 1'b0, 16'h000F, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst busy", {31'd0, busy16}, 0);
    check("rst done", {31'd0, done16}, 0);
    check("rst s", {16'd0, s16}, 0);
    check("rst c_out", {31'd0, cout16}, 0);
    check("rst add bus", {23'd0, aa16, ab16, acin16}, 0);
    rst_n = 1'b1;

    foreach (vt[i])
      run_op(vt[i].w, vt[i].a, vt[i].b, vt[i].cin, vt[i].s, vt[i].co,
             $sformatf("vec%0d", i));

    // Start while busy is ignored: one done, first operands' sum.
    ndone = 0;
    cap_s = '0;
    @(negedge clk);
    a16 = 16'h0100; b16 = 16'h0200; cin16 = 1'b0; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 2) begin a16 = 16'hFFFF; start16 = 1'b1; end
      if (k == 3) start16 = 1'b0;
      if (done16) begin ndone++; cap_s = s16; end
    end
    check("ignore start done count", ndone, 1);
    check("ignore start s", {16'd0, cap_s}, 32'h0300);

    // Back-to-back with start held high: done every N+1 cycles.
    ops_a[0] = 16'h1111; ops_b[0] = 16'h2222; ops_c[0] = 1'b0;
    ops_a[1] = 16'hF00F; ops_b[1] = 16'h0FF1; ops_c[1] = 1'b1;
    ops_a[2] = 16'hABCD; ops_b[2] = 16'h5433; ops_c[2] = 1'b0;
    ndone = 0; acc = 0; last_k = 0; busy_prev = 1'b0;
    @(negedge clk);
    a16 = ops_a[0]; b16 = ops_b[0]; cin16 = ops_c[0]; start16 = 1'b1;
    for (int k = 0; k < 40 && ndone < 3; k++) begin
      @(posedge clk); #1;
      if (done16) begin
        check($sformatf("b2b s%0d", ndone), {15'd0, cout16, s16},
              {16'd0, ops_a[ndone]} + {16'd0, ops_b[ndone]} + {31'd0, ops_c[ndone]});
        if (ndone == 0) check("b2b first latency", k, 4);
        else            check($sformatf("b2b interval%0d", ndone), k - last_k, 5);
        last_k = k;
        ndone++;
      end
      if (busy16 && !busy_prev) begin
        acc++;
        if (acc < 3) begin
          a16 = ops_a[acc]; b16 = ops_b[acc]; cin16 = ops_c[acc];
        end else begin
          start16 = 1'b0;
        end
      end
      busy_prev = busy16;
    end
    start16 = 1'b0;
    check("b2b done count", ndone, 3);

    // Asynchronous reset two cycles into RUN aborts the sum.
    @(negedge clk);
    a16 = 16'h1234; b16 = 16'h1111; cin16 = 1'b0; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("abort busy", {31'd0, busy16}, 0);
    check("abort s", {16'd0, s16}, 0);
    check("abort c_out", {31'd0, cout16}, 0);
    check("abort add_a", {28'd0, aa16}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done16) ndone++;
    end
    check("abort no done", ndone, 0);
    run_op(16, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, "post-reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
